// File: rtl/rx_flow_fifo.sv
// UART receive FIFO with XON/XOFF flow control.
// Control bytes share the transmit holding register with keyboard traffic.
module rx_flow_fifo #(
    parameter int DEPTH = 64,
    parameter int PTR_BITS = 6,
    parameter int HI_WATER = 48,
    parameter int LO_WATER = 16,
    parameter logic [7:0] XOFF_CHAR = 8'h13,
    parameter logic [7:0] XON_CHAR = 8'h11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic [7:0]          kbd_data,
    input  logic                kbd_valid,
    output logic                kbd_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [PTR_BITS:0]   level,
    output logic                overflow,
    output logic                xoff_active
);

    typedef enum logic [1:0] {
        FLOW_ON,
        XOFF_PEND,
        FLOW_OFF,
        XON_PEND
    } flow_t;

    localparam logic [PTR_BITS:0] FULL_LVL = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0] HI_LVL = (PTR_BITS+1)'(HI_WATER);
    localparam logic [PTR_BITS:0] LO_LVL = (PTR_BITS+1)'(LO_WATER);

    logic [7:0]          mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   level_q;

    logic full;
    logic rx_fire;
    logic push;
    logic pop;
    logic drop;

    flow_t state_q;
    flow_t state_d;
    logic  ctrl_done;
    logic  held_ctrl;
    logic  tx_fire;
    logic  can_load;
    logic  load_ctrl;
    logic  load_kbd;
    logic [7:0] ctrl_char;

    // The UART is never back-pressured; a full FIFO drops instead.
    assign rx_ready = ~reset;

    assign full = (level_q == FULL_LVL);
    assign rx_fire = rx_valid & rx_ready;
    assign pop = out_valid & out_ready;
    assign push = rx_fire & (~full | pop);
    assign drop = rx_fire & full & ~pop;

    assign out_valid = (level_q != '0);
    assign out_data = mem[rd_ptr];
    assign level = level_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level_q <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign tx_fire = tx_valid & tx_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FLOW_ON: begin
                if (level_q >= HI_LVL) state_d = XOFF_PEND;
            end
            XOFF_PEND: begin
                if (tx_fire && held_ctrl) state_d = FLOW_OFF;
            end
            FLOW_OFF: begin
                if (level_q <= LO_LVL) state_d = XON_PEND;
            end
            XON_PEND: begin
                if (tx_fire && held_ctrl) state_d = FLOW_ON;
            end
            default: state_d = FLOW_ON;
        endcase
    end

    always_comb begin
        can_load = ~tx_valid | tx_ready;
        load_ctrl = 1'b0;
        load_kbd = 1'b0;
        ctrl_char = XON_CHAR;
        if (state_q == XOFF_PEND) begin
            ctrl_char = XOFF_CHAR;
        end
        // A pending control byte waits for the register, never evicts it.
        if (!reset && can_load) begin
            if ((state_q == XOFF_PEND || state_q == XON_PEND) && !ctrl_done) begin
                load_ctrl = 1'b1;
            end else if (kbd_valid) begin
                load_kbd = 1'b1;
            end
        end
    end

    assign kbd_ready = load_kbd;
    assign xoff_active = (state_q == FLOW_OFF) || (state_q == XON_PEND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FLOW_ON;
            ctrl_done <= 1'b0;
            held_ctrl <= 1'b0;
            tx_valid <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                ctrl_done <= 1'b0;
            end else if (load_ctrl) begin
                ctrl_done <= 1'b1;
            end
            if (load_ctrl) begin
                tx_data <= ctrl_char;
                tx_valid <= 1'b1;
                held_ctrl <= 1'b1;
            end else if (load_kbd) begin
                tx_data <= kbd_data;
                tx_valid <= 1'b1;
                held_ctrl <= 1'b0;
            end else if (tx_fire) begin
                tx_valid <= 1'b0;
                held_ctrl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_flow_fifo.sv
// Bench for rx_flow_fifo: directed scenarios plus random traffic
// against a queue-based model of the FIFO and flow-control rules.
module tb_rx_flow_fifo;

    localparam int DEPTH = 64;
    localparam int PB = 6;
    localparam int HI = 48;
    localparam int LO = 16;
    localparam int M_ON = 0;
    localparam int M_XW = 1;
    localparam int M_OFF = 2;
    localparam int M_NW = 3;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    logic [7:0] out_data;
    logic out_valid;
    logic out_ready;
    logic [7:0] kbd_data;
    logic kbd_valid;
    logic kbd_ready;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic [PB:0] level;
    logic overflow;
    logic xoff_active;

    always #5 clk = ~clk;

    rx_flow_fifo dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .kbd_data(kbd_data),
        .kbd_valid(kbd_valid),
        .kbd_ready(kbd_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .level(level),
        .overflow(overflow),
        .xoff_active(xoff_active)
    );

    int total = 0;
    int bad = 0;
    int n_xoff = 0;
    int n_xon = 0;
    int maxlvl = 0;
    bit started = 0;
    byte unsigned q[$];
    byte unsigned kq[$];
    bit ovf_m;
    int mode = M_ON;
    bit prev_hold;
    logic [7:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: byte queue for the FIFO, abstract flow mode, keyboard order.
    always @(negedge clk) begin : model
        int sz;
        bit pop_m;
        bit push_m;
        bit acc;
        if (reset) begin
            q.delete();
            kq.delete();
            ovf_m = 0;
            mode = M_ON;
            prev_hold = 0;
            started = 1;
        end else if (started) begin
            sz = q.size();
            chk("level", level, sz);
            chk("out_valid", out_valid, sz != 0);
            if (sz != 0) chk("out_data", out_data, q[0]);
            chk("overflow", overflow, ovf_m);
            chk("xoff_active", xoff_active, mode == M_OFF || mode == M_NW);
            chk("rx_ready", rx_ready, 1);
            if (kbd_ready) begin
                chk("kbd_rdy_valid", kbd_valid, 1);
                chk("kbd_rdy_busy", tx_valid && !tx_ready, 0);
            end
            if (prev_hold) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_data", tx_data, prev_data);
            end
            pop_m = (sz != 0) && out_ready;
            push_m = rx_valid && (sz < DEPTH || pop_m);
            acc = tx_valid && tx_ready;
            if (acc && tx_data == 8'h13) begin
                chk("xoff_when", mode, M_XW);
                n_xoff++;
            end else if (acc && tx_data == 8'h11) begin
                chk("xon_when", mode, M_NW);
                n_xon++;
            end else if (acc) begin
                chk("tx_kbd_avail", kq.size() != 0, 1);
                if (kq.size() != 0) begin
                    chk("tx_kbd_data", tx_data, kq[0]);
                    void'(kq.pop_front());
                end
            end
            case (mode)
                M_ON: if (sz >= HI) mode = M_XW;
                M_XW: if (acc && tx_data == 8'h13) mode = M_OFF;
                M_OFF: if (sz <= LO) mode = M_NW;
                default: if (acc && tx_data == 8'h11) mode = M_ON;
            endcase
            if (kbd_valid && kbd_ready) kq.push_back(kbd_data);
            if (rx_valid && !push_m) ovf_m = 1;
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back(rx_data);
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (q.size() > maxlvl) maxlvl = q.size();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        rx_valid = 0;
        out_ready = 0;
        kbd_valid = 0;
        step();
        step();
        reset = 0;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1;
            rx_data = 8'(base + i);
            step();
        end
        rx_valid = 0;
    endtask

    initial begin
        int x0;
        int n0;
        int pr[6];
        int po[6];
        reset = 1;
        rx_valid = 0;
        rx_data = 0;
        out_ready = 0;
        kbd_valid = 0;
        kbd_data = 0;
        tx_ready = 0;
        do_reset();
        @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_kbd_ready", kbd_ready, 0);
        chk("rst_xoff", xoff_active, 0);
        chk("rst_rx_ready", rx_ready, 1);
        step();

        // Three bytes in, then drained in order.
        tx_ready = 1;
        push_n(3, 8'h41);
        @(negedge clk);
        chk("fill3_level", level, 3);
        chk("fill3_head", out_data, 8'h41);
        step();
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pop_order", out_data, 8'h41 + i);
            step();
        end
        out_ready = 0;
        @(negedge clk);
        chk("drained_valid", out_valid, 0);
        step();

        // High water emits XOFF once; low water emits XON once.
        do_reset();
        tx_ready = 1;
        x0 = n_xoff;
        n0 = n_xon;
        push_n(48, 0);
        for (int i = 0; i < 20 && xoff_active !== 1'b1; i++) step();
        @(negedge clk);
        chk("xoff_set", xoff_active, 1);
        chk("xoff_once", n_xoff - x0, 1);
        step();
        out_ready = 1;
        repeat (32) step();
        out_ready = 0;
        for (int i = 0; i < 20 && xoff_active !== 1'b0; i++) step();
        @(negedge clk);
        chk("xon_clear", xoff_active, 0);
        chk("xon_once", n_xon - n0, 1);
        chk("xoff_still_once", n_xoff - x0, 1);
        chk("lo_level", level, 16);
        step();

        // Full FIFO drops, simultaneous push/pop at full is accepted.
        do_reset();
        tx_ready = 1;
        push_n(64, 100);
        push_n(1, 8'hFF);
        @(negedge clk);
        chk("full_level", level, 64);
        chk("full_ovf", overflow, 1);
        chk("full_head", out_data, 100);
        step();
        rx_valid = 1;
        rx_data = 8'h5A;
        out_ready = 1;
        step();
        rx_valid = 0;
        out_ready = 0;
        @(negedge clk);
        chk("pp_full_level", level, 64);
        chk("pp_full_head", out_data, 101);
        step();
        out_ready = 1;
        repeat (64) step();
        out_ready = 0;
        @(negedge clk);
        chk("empty_level", level, 0);
        chk("ovf_sticky", overflow, 1);
        step();
        do_reset();
        @(negedge clk);
        chk("ovf_cleared", overflow, 0);
        step();

        // Held keyboard byte is not preempted; XOFF precedes next byte.
        do_reset();
        tx_ready = 0;
        kbd_valid = 1;
        kbd_data = 8'h61;
        @(negedge clk);
        chk("kbd_take", kbd_ready, 1);
        step();
        kbd_valid = 0;
        push_n(48, 0);
        kbd_valid = 1;
        kbd_data = 8'h62;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("kbd_held", tx_data, 8'h61);
            chk("kbd_blocked", kbd_ready, 0);
            step();
        end
        tx_ready = 1;
        @(negedge clk);
        chk("kbd_waits", kbd_ready, 0);
        step();
        @(negedge clk);
        chk("xoff_next", tx_data, 8'h13);
        chk("kbd_after_xoff", kbd_ready, 1);
        step();
        kbd_valid = 0;
        @(negedge clk);
        chk("kbd2_out", tx_data, 8'h62);
        step();

        // Pointer wrap with level held at one.
        do_reset();
        maxlvl = 0;
        tx_ready = 1;
        rx_valid = 1;
        out_ready = 1;
        for (int i = 0; i < 200; i++) begin
            rx_data = 8'($urandom);
            step();
        end
        rx_valid = 0;
        step();
        out_ready = 0;
        @(negedge clk);
        chk("wrap_max", maxlvl, 1);
        chk("wrap_level", level, 0);
        chk("wrap_ovf", overflow, 0);
        step();

        // Reset while XOFF sits in the holding register.
        do_reset();
        tx_ready = 0;
        push_n(50, 0);
        step();
        step();
        @(negedge clk);
        chk("pend_held", tx_data, 8'h13);
        chk("pend_level", level, 50);
        step();
        x0 = n_xoff;
        n0 = n_xon;
        reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_xoff", xoff_active, 0);
        step();
        tx_ready = 1;
        repeat (20) step();
        @(negedge clk);
        chk("no_xoff_after", n_xoff - x0, 0);
        chk("no_xon_after", n_xon - n0, 0);
        chk("idle_tx", tx_valid, 0);
        step();

        // Random traffic in phases that sweep the thresholds.
        pr = '{90, 10, 95, 20, 60, 30};
        po = '{10, 90, 5, 80, 50, 70};
        do_reset();
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 300; i++) begin
                rx_valid = ($urandom_range(99) < pr[p]);
                rx_data = 8'($urandom);
                out_ready = ($urandom_range(99) < po[p]);
                kbd_valid = ($urandom_range(3) == 0);
                kbd_data = 8'($urandom_range(126, 32));
                tx_ready = 1'($urandom_range(1));
                step();
            end
        end
        rx_valid = 0;
        out_ready = 0;
        kbd_valid = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
